// File: rtl/seg_scan_driver_pkg.sv
// ============================================================================
// Module  : seg_scan_driver_pkg
// Brief   : Segment glyphs, digit codes and snapshot type for the scan driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_driver_pkg;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low, bit order {dp,g,f,e,d,c,b,a}; dp bit is left off here.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic [3:0][3:0] code;
        logic [3:0]      dp;
        logic [3:0]      blink;
        logic            lz;
    } snap_t;

    localparam snap_t SNAP_RESET = '{code: 16'hFFFF, dp: 4'h0, blink: 4'h0, lz: 1'b0};

endpackage

`default_nettype wire

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// ============================================================================
// Module  : bcd_to_seg
// Brief   : Combinational digit-code to active-low segment decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       dp_i,
    output logic [7:0] segs_o
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        case (code_i)
            4'd0:      glyph = SEG_0;
            4'd1:      glyph = SEG_1;
            4'd2:      glyph = SEG_2;
            4'd3:      glyph = SEG_3;
            4'd4:      glyph = SEG_4;
            4'd5:      glyph = SEG_5;
            4'd6:      glyph = SEG_6;
            4'd7:      glyph = SEG_7;
            4'd8:      glyph = SEG_8;
            4'd9:      glyph = SEG_9;
            CODE_DASH: glyph = SEG_DASH;
            default:   glyph = SEG_BLANK;
        endcase
        segs_o = {~dp_i, glyph[6:0]};
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module  : seg_scan_driver
// Brief   : 4-digit multiplexed 7-segment scanner with frame snapshot,
//           leading-zero suppression and per-digit blink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in0_i,
    input  logic [3:0] in1_i,
    input  logic [3:0] in2_i,
    input  logic [3:0] in3_i,
    input  logic [3:0] dp_i,
    input  logic [3:0] blink_i,
    input  logic       lz_blank_i,
    output logic [3:0] ssd_ctl_o,
    output logic [7:0] segs_o,
    output logic       frame_tick_o
);

    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [15:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    snap_t       snap_q, snap_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [3:0]  ssd_ctl_q, ssd_ctl_d;
    logic [7:0]  segs_q, segs_d;
    logic        frame_tick_q, frame_tick_d;

    logic        slot_tick;
    logic        snap_load;
    logic        blank;
    logic [3:0]  cur_code;
    logic [7:0]  dec_segs;

    bcd_to_seg u_dec (
        .code_i (cur_code),
        .dp_i   (snap_q.dp[idx_q]),
        .segs_o (dec_segs)
    );

    always_comb begin
        slot_tick     = (div_q == DIV_LAST);
        snap_load     = slot_tick && (idx_q == 2'd3);
        div_d         = slot_tick ? 16'd0 : div_q + 16'd1;
        idx_d         = slot_tick ? idx_q + 2'd1 : idx_q;
        snap_d        = snap_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_tick_d  = snap_load;

        // Inputs are captured only at the frame boundary so a frame never tears.
        if (snap_load) begin
            snap_d.code  = {in3_i, in2_i, in1_i, in0_i};
            snap_d.dp    = dp_i;
            snap_d.blink = blink_i;
            snap_d.lz    = lz_blank_i;
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + 8'd1;
            end
        end

        cur_code  = snap_q.code[idx_q];
        blank     = (blink_phase_q && snap_q.blink[idx_q]) ||
                    ((idx_q == 2'd3) && snap_q.lz && (snap_q.code[3] == 4'd0));
        ssd_ctl_d = ~(4'b0001 << idx_q);
        segs_d    = blank ? SEG_BLANK : dec_segs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= 16'd0;
            idx_q         <= 2'd0;
            snap_q        <= SNAP_RESET;
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
            ssd_ctl_q     <= 4'b1111;
            segs_q        <= SEG_BLANK;
            frame_tick_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            ssd_ctl_q     <= ssd_ctl_d;
            segs_q        <= segs_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign ssd_ctl_o    = ssd_ctl_q;
    assign segs_o       = segs_q;
    assign frame_tick_o = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module  : tb_seg_scan_driver
// Brief   : Self-checking bench for seg_scan_driver (scoreboard + directed tasks).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in0 = 4'd0, in1 = 4'd0, in2 = 4'd0, in3 = 4'd0;
    logic [3:0] dp = 4'd0, blink = 4'd0;
    logic       lz = 1'b0;
    logic [3:0] ssd_ctl;
    logic [7:0] segs;
    logic       frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] ctl;
        logic [7:0] segs;
    } exp_t;
    exp_t sbq[$];

    seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0_i        (in0),
        .in1_i        (in1),
        .in2_i        (in2),
        .in3_i        (in3),
        .dp_i         (dp),
        .blink_i      (blink),
        .lz_blank_i   (lz),
        .ssd_ctl_o    (ssd_ctl),
        .segs_o       (segs),
        .frame_tick_o (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            4'd9: return 8'h90;  4'd10: return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] expect_seg(input int d, input logic [3:0] code,
                                              input logic dpb, input logic blb,
                                              input logic ph, input logic lzf,
                                              input logic [3:0] c3);
        logic [7:0] g;
        if (ph && blb) return 8'hFF;
        if (d == 3 && lzf && c3 == 4'd0) return 8'hFF;
        g = glyph(code);
        if (dpb) g[7] = 1'b0;
        return g;
    endfunction

    // Inputs as seen at each rising edge, so the snapshot edge is known exactly.
    logic [3:0] li0, li1, li2, li3, ldp, lbl;
    logic       llz;
    always @(posedge clk) begin
        li0 <= in0; li1 <= in1; li2 <= in2; li3 <= in3;
        ldp <= dp;  lbl <= blink; llz <= lz;
    end

    logic [3:0] prev_ctl = 4'hF;
    int         slot_len = 0;
    int         loads    = 0;
    int         cyc      = 0;
    int         last_ft  = -1;

    always @(negedge clk) begin
        exp_t       e;
        logic       ph;
        logic [3:0] codes [4];
        if (!rst_n) begin
            sbq.delete();
            prev_ctl = 4'hF;
            slot_len = 0;
            loads    = 0;
            cyc      = 0;
            last_ft  = -1;
        end else begin
            cyc++;
            if (frame_tick) begin
                if (last_ft >= 0) begin
                    vectors++;
                    if (cyc - last_ft !== 16) begin
                        miscompares++;
                        $display("FAIL frame_period: got %0d cycles, want 16", cyc - last_ft);
                    end
                end
                last_ft = cyc;
                loads++;
                ph = ((loads / BF) % 2) == 1;
                codes[0] = li0; codes[1] = li1; codes[2] = li2; codes[3] = li3;
                for (int d = 0; d < 4; d++) begin
                    e.ctl  = ~(4'b0001 << d);
                    e.segs = expect_seg(d, codes[d], ldp[d], lbl[d], ph, llz, li3);
                    sbq.push_back(e);
                end
            end
            if (ssd_ctl !== prev_ctl) begin
                if (prev_ctl != 4'hF) begin
                    vectors++;
                    if (slot_len != SD) begin
                        miscompares++;
                        $display("FAIL slot_len: got %0d cycles, want %0d", slot_len, SD);
                    end
                end
                vectors++;
                if ($countones(~ssd_ctl) != 1) begin
                    miscompares++;
                    $display("FAIL one_cold: ssd_ctl=%b", ssd_ctl);
                end
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                end else begin
                    e.ctl  = (prev_ctl == 4'hF) ? 4'b1110 : {prev_ctl[2:0], prev_ctl[3]};
                    e.segs = 8'hFF;
                end
                vectors++;
                if (ssd_ctl !== e.ctl || segs !== e.segs) begin
                    miscompares++;
                    $display("FAIL scoreboard: got ctl=%b segs=%h, want ctl=%b segs=%h",
                             ssd_ctl, segs, e.ctl, e.segs);
                end
                slot_len = 1;
                prev_ctl = ssd_ctl;
            end else begin
                slot_len++;
            end
        end
    end

    task automatic wait_ft(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_frame_tick: got timeout, want frame_tick within 100 cycles");
        end
    endtask

    task automatic wait_ctl(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ssd_ctl === v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ctl: got timeout, want ssd_ctl=%b", v);
        end
    endtask

    task automatic chk_segs(input string name, input logic [7:0] want);
        vectors++;
        if (segs !== want) begin
            miscompares++;
            $display("FAIL %s: got segs=%h, want %h", name, segs, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in3 = 4'd1; in2 = 4'd2; in1 = 4'd3; in0 = 4'd4;
        dp = 4'd0; blink = 4'd0; lz = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ssd_ctl !== 4'b1111 || segs !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ctl=%b segs=%h ft=%b, want 1111 ff 0",
                     ssd_ctl, segs, frame_tick);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (ssd_ctl !== 4'b1110 || segs !== 8'hFF) begin
            miscompares++;
            $display("FAIL first_clock: got ctl=%b segs=%h, want 1110 ff", ssd_ctl, segs);
        end
    endtask

    task automatic test_first_frame();
        bit ok;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
            chk_segs("prewrap_blank", 8'hFF);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL first_frame_tick: got timeout, want frame_tick");
        end
        wait_ctl(4'b1110, ok);
        if (ok) chk_segs("digit0_4", 8'h99);
        wait_ctl(4'b0111, ok);
        if (ok) chk_segs("digit3_1", 8'hF9);
    endtask

    task automatic test_slot_timing();
        bit ok;
        int n;
        wait_ctl(4'b1101, ok);
        n = 1;
        while (ssd_ctl === 4'b1101 && n < 50) begin
            @(negedge clk);
            if (ssd_ctl === 4'b1101) n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL slot_hold: got %0d cycles, want 4", n);
        end
        wait_ft(ok);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (frame_tick) break;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL frame_tick_period: got %0d cycles, want 16", n);
        end
    endtask

    task automatic test_tearing();
        bit ok;
        wait_ctl(4'b1011, ok);
        @(negedge clk);
        in0 = 4'd7;
        wait_ctl(4'b0111, ok);
        if (ok) chk_segs("tear_digit3", 8'hF9);
        wait_ft(ok);
        wait_ctl(4'b1110, ok);
        if (ok) chk_segs("tear_digit0_7", 8'hF8);
    endtask

    task automatic test_special();
        bit ok;
        @(negedge clk);
        lz = 1'b1; in3 = 4'd0; in2 = 4'd10; in1 = 4'd13;
        wait_ft(ok);
        wait_ctl(4'b1101, ok);
        if (ok) chk_segs("code13_blank", 8'hFF);
        wait_ctl(4'b1011, ok);
        if (ok) chk_segs("code10_dash", 8'hBF);
        wait_ctl(4'b0111, ok);
        if (ok) chk_segs("lz_blank", 8'hFF);
        @(negedge clk);
        in1 = 4'd5; dp = 4'b0010; lz = 1'b0;
        wait_ft(ok);
        wait_ctl(4'b1101, ok);
        if (ok) chk_segs("dp_digit1_5", 8'h12);
        wait_ctl(4'b0111, ok);
        if (ok) chk_segs("zero_no_lz", 8'hC0);
    endtask

    task automatic test_blink();
        bit ok;
        int lit = 0;
        @(negedge clk);
        in3 = 4'd1; in2 = 4'd2; in1 = 4'd3; in0 = 4'd4;
        dp = 4'd0; lz = 1'b0; blink = 4'b0001;
        wait_ft(ok);
        for (int f = 0; f < 8; f++) begin
            wait_ft(ok);
            wait_ctl(4'b1110, ok);
            if (ok) begin
                chk_segs("blink_digit0", (((loads / BF) % 2) == 1) ? 8'hFF : 8'h99);
                if (segs === 8'h99) lit++;
            end
            wait_ctl(4'b1101, ok);
            if (ok) chk_segs("blink_digit1_steady", 8'hB0);
        end
        vectors++;
        if (lit != 4) begin
            miscompares++;
            $display("FAIL blink_duty: got %0d lit frames of 8, want 4", lit);
        end
        @(negedge clk);
        blink = 4'd0;
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_ft(ok);
        wait_ctl(4'b1011, ok);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ssd_ctl !== 4'b1111 || segs !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got ctl=%b segs=%h ft=%b, want 1111 ff 0",
                     ssd_ctl, segs, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (ssd_ctl !== 4'b1110 || segs !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_recovery: got ctl=%b segs=%h, want 1110 ff", ssd_ctl, segs);
        end
        wait_ft(ok);
        wait_ctl(4'b1110, ok);
        if (ok) chk_segs("post_reset_digit0", 8'h99);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_slot_timing();
        test_tearing();
        test_special();
        test_blink();
        test_async_reset();
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
